// File: rtl/gray_frame_ctrl_if.sv
// Signal bundle between the grayscale frame sequencer and its environment:
// start/config, source memory read port, grayscale datapath and result sink.
interface gray_frame_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10
);
  logic              start;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic              busy;
  logic              done;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;

  logic [7:0]        dp_red;
  logic [7:0]        dp_green;
  logic [7:0]        dp_blue;
  logic              dp_valid;
  logic [7:0]        dp_gray;

  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_eol;
  logic              wr_last;

  modport master (
    input  start, cfg_width, cfg_height, rd_data, dp_gray, wr_ready,
    output busy, done, rd_en, rd_addr, dp_red, dp_green, dp_blue, dp_valid,
           wr_en, wr_addr, wr_data, wr_eol, wr_last
  );

  modport slave (
    output start, cfg_width, cfg_height, rd_data, dp_gray, wr_ready,
    input  busy, done, rd_en, rd_addr, dp_red, dp_green, dp_blue, dp_valid,
           wr_en, wr_addr, wr_data, wr_eol, wr_last
  );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: streams a WxH RGB frame from source memory through the
// fixed-latency grayscale datapath into a credit-limited skid FIFO feeding the sink.
module gray_frame_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 10,
  parameter int GRAY_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  gray_frame_ctrl_if.master io_frame
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + GRAY_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [DIM_W-1:0]  r_width;
  logic [ADDR_W-1:0] r_lastIdx;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DIM_W-1:0]  r_col;
  logic [GRAY_LAT:0] r_vpipe;

  logic [7:0]        r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_busy;
  logic              w_done;
  logic              w_rdEn;
  logic              w_dimsOk;
  logic              w_startRun;
  logic              w_push;
  logic              w_pop;
  logic              w_fifoEmpty;
  logic              w_fifoFull;
  logic              w_wrEol;
  logic              w_wrLast;
  logic [ADDR_W-1:0] w_frameLen;
  logic [SUM_W-1:0]  w_inflight;
  logic [SUM_W-1:0]  w_credit;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_dimsOk   = (io_frame.cfg_width != '0) && (io_frame.cfg_height != '0);
  assign w_startRun = (r_state == S_IDLE) && io_frame.start && w_dimsOk;
  assign w_frameLen = ADDR_W'(io_frame.cfg_width) * ADDR_W'(io_frame.cfg_height);

  // Reads still in the datapath each own a FIFO slot, so they count against the credit.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= GRAY_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_vpipe[i]);
    end
  end

  assign w_credit = w_inflight + SUM_W'(r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rdEn      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_frame.start) begin
          w_stateNext = w_dimsOk ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_rdEn = (w_credit < SUM_W'(FIFO_DEPTH));
        if (w_rdEn && (r_rdAddr == r_lastIdx)) begin
          w_stateNext = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_pop && w_wrLast) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_width   <= '0;
      r_lastIdx <= '0;
      r_rdAddr  <= '0;
      r_wrAddr  <= '0;
      r_col     <= '0;
    end else if (w_startRun) begin
      r_width   <= io_frame.cfg_width;
      r_lastIdx <= w_frameLen - ADDR_W'(1);
      r_rdAddr  <= '0;
      r_wrAddr  <= '0;
      r_col     <= '0;
    end else begin
      if (w_rdEn) begin
        r_rdAddr <= r_rdAddr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_wrAddr <= r_wrAddr + ADDR_W'(1);
        r_col    <= w_wrEol ? '0 : r_col + DIM_W'(1);
      end
    end
  end

  // Bit 0 marks dp_valid; the top bit marks dp_gray valid for capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_rdEn;
      for (int i = 1; i <= GRAY_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  assign w_push      = r_vpipe[GRAY_LAT];
  assign w_fifoEmpty = (r_count == '0);
  assign w_fifoFull  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = !w_fifoEmpty && io_frame.wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoMem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifoMem[r_tail] <= io_frame.dp_gray;
        r_tail            <= ptrInc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptrInc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign w_wrEol  = !w_fifoEmpty && (r_col == (r_width - DIM_W'(1)));
  assign w_wrLast = !w_fifoEmpty && (r_wrAddr == r_lastIdx);

  assign io_frame.busy     = w_busy;
  assign io_frame.done     = w_done;
  assign io_frame.rd_en    = w_rdEn;
  assign io_frame.rd_addr  = r_rdAddr;
  assign io_frame.dp_valid = r_vpipe[0];
  assign io_frame.dp_red   = r_vpipe[0] ? io_frame.rd_data[23:16] : 8'd0;
  assign io_frame.dp_green = r_vpipe[0] ? io_frame.rd_data[15:8]  : 8'd0;
  assign io_frame.dp_blue  = r_vpipe[0] ? io_frame.rd_data[7:0]   : 8'd0;
  assign io_frame.wr_en    = !w_fifoEmpty;
  assign io_frame.wr_addr  = r_wrAddr;
  assign io_frame.wr_data  = w_fifoEmpty ? 8'd0 : r_fifoMem[r_head];
  assign io_frame.wr_eol   = w_wrEol;
  assign io_frame.wr_last  = w_wrLast;

  a_noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_fifoFull));

  a_holdWhileStalled: assert property (@(posedge clk) disable iff (rst)
    (io_frame.wr_en && !io_frame.wr_ready) |=>
      (io_frame.wr_en && $stable(io_frame.wr_data) && $stable(io_frame.wr_addr) &&
       $stable(io_frame.wr_eol) && $stable(io_frame.wr_last)));

endmodule
